// File: rtl/gpu_clk_pkg.sv
// rtl/gpu_clk_pkg.sv - shared state encoding and default timing constants for the reset sequencer
package gpu_clk_pkg;

    typedef enum logic [2:0] {
        S_WAIT_LOCK  = 3'd0,
        S_STABLE     = 3'd1,
        S_SDRAM_INIT = 3'd2,
        S_CORE_DLY   = 3'd3,
        S_CORE_ON    = 3'd4,
        S_RUN        = 3'd5
    } seq_state_e;

    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_CORE_DELAY_CYCLES   = 16;
    localparam int DEF_INIT_TIMEOUT_CYCLES = 1048576;

    // Reset release pattern {sdram, core, pixel} for a state; active-low, 1 = released.
    function automatic logic [2:0] rst_decode(input seq_state_e s);
        logic [2:0] r;
        case (s)
            S_SDRAM_INIT: r = 3'b100;
            S_CORE_DLY:   r = 3'b100;
            S_CORE_ON:    r = 3'b110;
            S_RUN:        r = 3'b111;
            default:      r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchroniser, deliberately without reset
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/gpu_reset_seq.sv
// rtl/gpu_reset_seq.sv - PLL-lock driven reset sequencer releasing sdram, core and pixel resets in order
module gpu_reset_seq
    import gpu_clk_pkg::*;
#(
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int CORE_DELAY_CYCLES   = DEF_CORE_DELAY_CYCLES,
    parameter int INIT_TIMEOUT_CYCLES = DEF_INIT_TIMEOUT_CYCLES
) (
    input  logic       clk_core,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sdram_init_done,
    output logic       rst_sdram_n,
    output logic       rst_core_n,
    output logic       rst_pixel_req_n,
    output logic       lock_lost,
    output logic       init_timeout,
    output logic [2:0] seq_state
);

    localparam int MAX_AB = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ? LOCK_STABLE_CYCLES
                                                                     : CORE_DELAY_CYCLES;
    localparam int MAX_P  = (MAX_AB > INIT_TIMEOUT_CYCLES) ? MAX_AB : INIT_TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(INIT_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             w_locked_s;
    seq_state_e       w_next;
    logic             w_set_lost;
    logic             w_set_tmo;

    seq_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rst_sdram_n;
    logic             r_rst_core_n;
    logic             r_rst_pixel_req_n;
    logic             r_lock_lost;
    logic             r_init_timeout;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk (clk_core),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    // Lock loss outranks every other transition, including a coincident init_done.
    always_comb begin
        w_next     = r_state;
        w_set_lost = 1'b0;
        w_set_tmo  = 1'b0;
        if (r_state != S_WAIT_LOCK && !w_locked_s) begin
            w_next     = S_WAIT_LOCK;
            w_set_lost = (r_state >= S_SDRAM_INIT);
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    if (w_locked_s) w_next = S_STABLE;
                end
                S_STABLE: begin
                    if (r_cnt == LOCK_LAST) w_next = S_SDRAM_INIT;
                end
                S_SDRAM_INIT: begin
                    if (sdram_init_done) begin
                        w_next = S_CORE_DLY;
                    end else if (r_cnt == TMO_LAST) begin
                        w_next    = S_WAIT_LOCK;
                        w_set_tmo = 1'b1;
                    end
                end
                S_CORE_DLY: begin
                    if (r_cnt == CORE_LAST) w_next = S_CORE_ON;
                end
                S_CORE_ON: w_next = S_RUN;
                S_RUN:     w_next = S_RUN;
                default:   w_next = S_WAIT_LOCK;
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk_core) begin
        if (!rst_n) begin
            r_state           <= S_WAIT_LOCK;
            r_cnt             <= '0;
            r_rst_sdram_n     <= 1'b0;
            r_rst_core_n      <= 1'b0;
            r_rst_pixel_req_n <= 1'b0;
            r_lock_lost       <= 1'b0;
            r_init_timeout    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            {r_rst_sdram_n, r_rst_core_n, r_rst_pixel_req_n} <= rst_decode(w_next);
            if (w_set_lost) r_lock_lost    <= 1'b1;
            if (w_set_tmo)  r_init_timeout <= 1'b1;
        end
    end

    assign rst_sdram_n     = r_rst_sdram_n;
    assign rst_core_n      = r_rst_core_n;
    assign rst_pixel_req_n = r_rst_pixel_req_n;
    assign lock_lost       = r_lock_lost;
    assign init_timeout    = r_init_timeout;
    assign seq_state       = r_state;

endmodule

// File: tb/tb_gpu_reset_seq.sv
// tb/tb_gpu_reset_seq.sv - scoreboard bench predicting every output change from the sequencer timing rules
module tb_gpu_reset_seq;
    import gpu_clk_pkg::*;

    localparam int SYNC     = 2;
    localparam int LOCK     = 8;
    localparam int CORE     = 4;
    localparam int TMO      = 32;
    localparam int LOCK_LAT = SYNC + 1 + LOCK;
    localparam int LOSS_LAT = SYNC + 1;
    localparam int CORE_LAT = CORE + 1;

    logic       clk_core = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sdram_init_done = 1'b0;
    logic       rst_sdram_n;
    logic       rst_core_n;
    logic       rst_pixel_req_n;
    logic       lock_lost;
    logic       init_timeout;
    logic [2:0] seq_state;

    gpu_reset_seq #(
        .SYNC_STAGES         (SYNC),
        .LOCK_STABLE_CYCLES  (LOCK),
        .CORE_DELAY_CYCLES   (CORE),
        .INIT_TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_core        (clk_core),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .sdram_init_done (sdram_init_done),
        .rst_sdram_n     (rst_sdram_n),
        .rst_core_n      (rst_core_n),
        .rst_pixel_req_n (rst_pixel_req_n),
        .lock_lost       (lock_lost),
        .init_timeout    (init_timeout),
        .seq_state       (seq_state)
    );

    always #5 clk_core = ~clk_core;

    int cyc = 0;
    always @(posedge clk_core) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] vec;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    bit         exp_lost = 1'b0;
    bit         exp_tmo = 1'b0;
    bit         mon_en = 1'b0;
    logic [7:0] prev_vec = '0;

    // Expected visible vector for a state: releases follow the state table, flags follow the model.
    function automatic logic [7:0] mk_vec(input seq_state_e st);
        logic [2:0] s;
        s = st;
        return {s, (s >= 3'd2), (s >= 3'd4), (s == 3'd5), exp_lost, exp_tmo};
    endfunction

    task automatic push(input int at, input seq_state_e st);
        ev_t e;
        e.at  = at;
        e.vec = mk_vec(st);
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_core);
        #2;
    endtask

    always @(negedge clk_core) begin
        logic [7:0] v;
        ev_t        e;
        v = {seq_state, rst_sdram_n, rst_core_n, rst_pixel_req_n, lock_lost, init_timeout};
        if (!mon_en) begin
            prev_vec = v;
        end else if (v !== prev_vec) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_change: cycle %0d vec %b, required no change from %b",
                         cyc, v, prev_vec);
            end else begin
                e = exp_q.pop_front();
                if (cyc == e.at && v === e.vec) n_pass++;
                else $display("FAIL event: cycle %0d vec %b, required cycle %0d vec %b",
                              cyc, v, e.at, e.vec);
            end
            prev_vec = v;
        end
    end

    // From a just-entered S_SDRAM_INIT: raise init_done after d cycles and follow it to S_RUN.
    task automatic init_to_run(input int d);
        int a;
        int q;
        step(d);
        a = cyc;
        sdram_init_done = 1'b1;
        push(a + 1, S_CORE_DLY);
        push(a + CORE_LAT, S_CORE_ON);
        push(a + CORE_LAT + 1, S_RUN);
        q = $urandom_range(1, CORE_LAT + 1);
        step(q);
        sdram_init_done = 1'b0;
        step(CORE_LAT + 2 - q);
    endtask

    // Drop the PLL lock for h cycles, then follow the re-lock up to S_SDRAM_INIT entry.
    task automatic lose_lock(input int h, input bit released);
        int k;
        k = cyc;
        pll_locked = 1'b0;
        if (released) exp_lost = 1'b1;
        push(k + LOSS_LAT, S_WAIT_LOCK);
        step(h);
        pll_locked = 1'b1;
        push(k + h + SYNC + 1, S_STABLE);
        push(k + h + LOCK_LAT, S_SDRAM_INIT);
        step(LOCK_LAT);
    endtask

    initial begin
        int k;
        int a;
        int r;
        int m;
        int b;

        step(3);
        n_checks++;
        if ({seq_state, rst_sdram_n, rst_core_n, rst_pixel_req_n, lock_lost, init_timeout} === 8'd0)
            n_pass++;
        else
            $display("FAIL reset_state: vec %b, required 00000000",
                     {seq_state, rst_sdram_n, rst_core_n, rst_pixel_req_n, lock_lost, init_timeout});
        mon_en = 1'b1;
        rst_n = 1'b1;
        step(2);

        // Nominal bring-up, init_done 10 cycles after sdram release.
        k = cyc;
        pll_locked = 1'b1;
        push(k + SYNC + 1, S_STABLE);
        push(k + LOCK_LAT, S_SDRAM_INIT);
        step(LOCK_LAT);
        init_to_run(10);

        // Lock loss in S_RUN; lock_lost must survive the full re-sequence.
        lose_lock($urandom_range(1, 6), 1'b1);
        init_to_run($urandom_range(0, 25));

        // rst_n during S_CORE_DLY aborts everything and clears both flags.
        lose_lock($urandom_range(1, 6), 1'b1);
        step($urandom_range(0, 10));
        a = cyc;
        sdram_init_done = 1'b1;
        push(a + 1, S_CORE_DLY);
        step(2 + $urandom_range(0, 2));
        r = cyc;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        sdram_init_done = 1'b0;
        exp_lost = 1'b0;
        exp_tmo = 1'b0;
        push(r + 1, S_WAIT_LOCK);
        m = $urandom_range(3, 5);
        step(m);
        rst_n = 1'b1;
        step(4);

        // One-cycle lock glitch at stabilisation count 5: restart without lock_lost.
        k = cyc;
        pll_locked = 1'b1;
        push(k + SYNC + 1, S_STABLE);
        step(SYNC + 1 + 5);
        lose_lock(1, 1'b0);

        // Init timeout, then automatic retry through to S_RUN.
        k = cyc;
        exp_tmo = 1'b1;
        push(k + TMO, S_WAIT_LOCK);
        push(k + TMO + 1, S_STABLE);
        push(k + TMO + 1 + LOCK, S_SDRAM_INIT);
        step(TMO + 1 + LOCK);
        init_to_run($urandom_range(0, 25));

        // init_done sampled on the same edge lock loss is seen: lock loss wins.
        lose_lock($urandom_range(1, 6), 1'b1);
        step($urandom_range(0, 10));
        b = cyc;
        pll_locked = 1'b0;
        push(b + LOSS_LAT, S_WAIT_LOCK);
        step(SYNC);
        sdram_init_done = 1'b1;
        step(1);
        sdram_init_done = 1'b0;
        pll_locked = 1'b1;
        push(b + LOSS_LAT + SYNC + 1, S_STABLE);
        push(b + LOSS_LAT + LOCK_LAT, S_SDRAM_INIT);
        step(LOCK_LAT);
        init_to_run($urandom_range(0, 25));

        for (int i = 0; i < 4; i++) begin
            lose_lock($urandom_range(1, 6), 1'b1);
            init_to_run($urandom_range(0, 25));
        end

        step(6);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule

// File: doc/gpu_reset_seq.md
# gpu_reset_seq

Reset sequencer directly downstream of the PLL. It synchronises the PLL lock indicator into the 100 MHz core domain, waits for lock to stay stable, and releases the SDRAM controller reset. After the SDRAM controller reports init complete, it releases the GPU core reset and then the display-domain reset request. Any loss of lock, or an SDRAM init timeout, re-asserts every downstream reset.

## Interface
Parameters:
- SYNC_STAGES, 2: flops in the pll_locked synchroniser (minimum 2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before the SDRAM reset is released (≥1).
- CORE_DELAY_CYCLES, 16: cycles between sdram_init_done and core reset release (≥1).
- INIT_TIMEOUT_CYCLES, 1048576: cycles allowed for sdram_init_done after SDRAM reset release (≥1).

Ports:
- clk_core  in  1  100 MHz core clock; the only clock.
- rst_n  in  1  synchronous, active-low reset (one clock, sync active-low reset; fixed).
- pll_locked  in  1  PLL lock, asynchronous to clk_core.
- sdram_init_done  in  1  level from the SDRAM controller, in the clk_core domain.
- rst_sdram_n  out  1  SDRAM controller reset, active-low, registered.
- rst_core_n  out  1  GPU core reset, active-low, registered.
- rst_pixel_req_n  out  1  active-low reset request; the pixel domain re-synchronises it.
- lock_lost  out  1  sticky flag: lock dropped after the first release; cleared only by rst_n.
- init_timeout  out  1  sticky flag: an SDRAM init timeout occurred; cleared only by rst_n.
- seq_state  out  3  current state encoding, for debug.

## Operation
- locked_s is pll_locked after SYNC_STAGES flops. The synchroniser flops are not reset.
- States and output values:
  - S_WAIT_LOCK (0): all reset outputs low.
  - S_STABLE (1): all reset outputs low.
  - S_SDRAM_INIT (2): rst_sdram_n high.
  - S_CORE_DLY (3): rst_sdram_n high.
  - S_CORE_ON (4): rst_sdram_n and rst_core_n high.
  - S_RUN (5): all reset outputs high.
- Transitions:
  - S_WAIT_LOCK: locked_s=1 → S_STABLE; counter cleared.
  - S_STABLE: counter increments each cycle while locked_s=1. When the counter reaches LOCK_STABLE_CYCLES-1 with locked_s=1 → S_SDRAM_INIT; counter cleared.
  - S_SDRAM_INIT: sdram_init_done=1 → S_CORE_DLY; counter cleared. Otherwise, counter reaching INIT_TIMEOUT_CYCLES-1 → S_WAIT_LOCK and set init_timeout.
  - S_CORE_DLY: counter reaching CORE_DELAY_CYCLES-1 → S_CORE_ON.
  - S_CORE_ON: after one cycle → S_RUN.
  - S_RUN: terminal while locked_s=1.
- Loss of lock: in any state except S_WAIT_LOCK, locked_s=0 → S_WAIT_LOCK, and this check has priority over every other transition. If the state was S_SDRAM_INIT or later, also set lock_lost. Loss during S_STABLE only restarts stabilisation.
- sdram_init_done falling while in S_CORE_DLY, S_CORE_ON or S_RUN is ignored. The SDRAM controller owns its own re-init.
- Counter: one shared counter, width $clog2 of the largest parameter plus 1, saturating, cleared on every state change.
- After a timeout, the sequence retries from S_WAIT_LOCK indefinitely.

## Timing
- On rst_n low (sampled at a clk_core edge): state = S_WAIT_LOCK; rst_sdram_n = rst_core_n = rst_pixel_req_n = 0; lock_lost = init_timeout = 0; counter = 0.
- rst_n asserted mid-sequence aborts it at the same edge with no partial release.
- All outputs are registered and decoded from the next state, so they change on the same edge the state changes.
- pll_locked rising to rst_sdram_n rising: SYNC_STAGES + 1 + LOCK_STABLE_CYCLES cycles, with lock held throughout.
- sdram_init_done sampled high to rst_core_n rising: CORE_DELAY_CYCLES + 1 cycles.
- rst_core_n rising to rst_pixel_req_n rising: exactly 1 cycle.
- pll_locked falling to all resets low: SYNC_STAGES + 1 cycles.
- Resets de-assert in the strict order sdram → core → pixel. They all assert together.

## Structure
- Shared gpu_clk_pkg: state enum (3 bits) and default constants for the parameters.
- Sub-module sync_bit (parameter STAGES, 1-bit, no reset) for the lock synchroniser; the display domain reuses it on rst_pixel_req_n.
- Sequencer FSM and counter live in gpu_reset_seq.

## Test plan
Bench parameters: LOCK_STABLE_CYCLES=8, CORE_DELAY_CYCLES=4, INIT_TIMEOUT_CYCLES=32, SYNC_STAGES=2.
- Nominal: release rst_n, raise pll_locked at cycle 0, raise sdram_init_done 10 cycles after rst_sdram_n → rst_sdram_n rises at cycle 11; rst_core_n rises 5 cycles after init_done is sampled; rst_pixel_req_n rises 1 cycle later; both flags stay 0.
- Lock glitch: drop pll_locked for 1 cycle during S_STABLE at count 5 → back to S_WAIT_LOCK; rst_sdram_n rises 11 cycles after the re-lock; lock_lost stays 0.
- Lock loss in S_RUN → all three resets low 3 cycles after pll_locked falls; lock_lost=1 and stays 1 through a full re-sequence.
- Init timeout: sdram_init_done held at 0 → 32 cycles after rst_sdram_n rises, the state returns to S_WAIT_LOCK, rst_sdram_n goes low, and init_timeout=1; the sequencer then retries automatically.
- Reset mid-sequence: assert rst_n during S_CORE_DLY → next edge shows state 0, all outputs 0, flags cleared.
- Simultaneous events: sdram_init_done rises on the same cycle locked_s falls in S_SDRAM_INIT → the lock-loss transition wins (S_WAIT_LOCK, lock_lost=1), and rst_core_n never pulses high.
